// File: rtl/portb_pkg.sv
// Shared op codes, default register map, FSM state type and the
// read-modify-write helper for the PORTB controller.
package portb_pkg;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  localparam logic [7:0] DEF_ADDR_PINB  = 8'h23;
  localparam logic [7:0] DEF_ADDR_DDRB  = 8'h24;
  localparam logic [7:0] DEF_ADDR_PORTB = 8'h25;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT  = 2'b01,
    COMMIT = 2'b10
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_TMR = 1'b1
  } grant_t;

  function automatic logic [7:0] apply_op(input logic [1:0] op,
                                          input logic [7:0] cur,
                                          input logic [7:0] mask);
    logic [7:0] res;
    case (op)
      OP_WRITE:  res = mask;
      OP_SET:    res = cur | mask;
      OP_CLEAR:  res = cur & ~mask;
      OP_TOGGLE: res = cur ^ mask;
      default:   res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/portb_sync2.sv
// Eight-bit two-flop synchronizer for the asynchronous PINB pin levels.
module portb_sync2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] d,
  output logic [7:0] q
);

  logic [7:0] meta;

  // two-stage capture; the first stage may go metastable
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= 8'h00;
      q    <= 8'h00;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/portb_ctrl.sv
// PORTB register block arbitrating a CPU bus and a timer toggle source
// through a three-state IDLE/GRANT/COMMIT transaction engine.
module portb_ctrl
  import portb_pkg::*;
#(
  parameter logic [7:0] ADDR_PINB  = DEF_ADDR_PINB,
  parameter logic [7:0] ADDR_DDRB  = DEF_ADDR_DDRB,
  parameter logic [7:0] ADDR_PORTB = DEF_ADDR_PORTB
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [1:0] cpu_op,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  input  logic       tmr_req,
  input  logic [7:0] tmr_mask,
  output logic       tmr_ack,
  input  logic [7:0] pinb_in,
  output logic       PORTB_write_en,
  output logic [7:0] PORTB_data,
  output logic [7:0] ddrb
);

  state_t     state;
  state_t     state_next;
  grant_t     last_grant;
  grant_t     grant;
  grant_t     pick;

  logic       txn_we;
  logic [7:0] txn_addr;
  logic [1:0] txn_op;
  logic [7:0] txn_wdata;
  logic [7:0] txn_mask;

  logic [7:0] shadow;
  logic [7:0] pinb_sync;
  logic [7:0] new_shadow;
  logic [7:0] new_ddrb;
  logic [7:0] rd_val;
  logic       do_strobe;

  portb_sync2 u_sync (
    .clock (clock),
    .reset (reset),
    .d     (pinb_in),
    .q     (pinb_sync)
  );

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state: every transaction takes exactly three cycles
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cpu_req || tmr_req) begin
          state_next = GRANT;
        end else begin
          state_next = IDLE;
        end
      end
      GRANT:   state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // arbitration; a tie goes to whichever side did not win last time
  always_comb begin
    pick = GNT_CPU;
    if (cpu_req && tmr_req) begin
      if (last_grant == GNT_TMR) begin
        pick = GNT_CPU;
      end else begin
        pick = GNT_TMR;
      end
    end else if (tmr_req) begin
      pick = GNT_TMR;
    end else begin
      pick = GNT_CPU;
    end
  end

  // latch winner and request fields so later input changes are ignored
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= GNT_TMR;
      grant      <= GNT_CPU;
      txn_we     <= 1'b0;
      txn_addr   <= 8'h00;
      txn_op     <= 2'b00;
      txn_wdata  <= 8'h00;
      txn_mask   <= 8'h00;
    end else if (state == IDLE && (cpu_req || tmr_req)) begin
      last_grant <= pick;
      grant      <= pick;
      txn_we     <= cpu_we;
      txn_addr   <= cpu_addr;
      txn_op     <= cpu_op;
      txn_wdata  <= cpu_wdata;
      txn_mask   <= tmr_mask;
    end else begin
      last_grant <= last_grant;
      grant      <= grant;
    end
  end

  // transaction decode evaluated while in GRANT
  always_comb begin
    new_shadow = shadow;
    new_ddrb   = ddrb;
    rd_val     = 8'h00;
    do_strobe  = 1'b0;
    if (grant == GNT_TMR) begin
      new_shadow = shadow ^ txn_mask;
      do_strobe  = 1'b1;
    end else if (txn_we) begin
      if (txn_addr == ADDR_PORTB) begin
        new_shadow = apply_op(txn_op, shadow, txn_wdata);
        do_strobe  = 1'b1;
      end else if (txn_addr == ADDR_DDRB) begin
        new_ddrb = apply_op(txn_op, ddrb, txn_wdata);
      end else if (txn_addr == ADDR_PINB) begin
        // PINB writes always toggle, whatever op the CPU asked for
        new_shadow = shadow ^ txn_wdata;
        do_strobe  = 1'b1;
      end else begin
        new_shadow = shadow;
      end
    end else begin
      if (txn_addr == ADDR_PORTB) begin
        rd_val = shadow;
      end else if (txn_addr == ADDR_DDRB) begin
        rd_val = ddrb;
      end else if (txn_addr == ADDR_PINB) begin
        rd_val = pinb_sync;
      end else begin
        rd_val = 8'h00;
      end
    end
  end

  // commit: state and all outputs registered on the GRANT->COMMIT edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow         <= 8'h00;
      ddrb           <= 8'h00;
      cpu_ack        <= 1'b0;
      tmr_ack        <= 1'b0;
      cpu_rdata      <= 8'h00;
      PORTB_write_en <= 1'b0;
      PORTB_data     <= 8'h00;
    end else if (state == GRANT) begin
      shadow         <= new_shadow;
      ddrb           <= new_ddrb;
      cpu_ack        <= (grant == GNT_CPU);
      tmr_ack        <= (grant == GNT_TMR);
      cpu_rdata      <= (grant == GNT_CPU) ? rd_val : 8'h00;
      PORTB_write_en <= do_strobe;
      PORTB_data     <= do_strobe ? new_shadow : 8'h00;
    end else begin
      cpu_ack        <= 1'b0;
      tmr_ack        <= 1'b0;
      cpu_rdata      <= 8'h00;
      PORTB_write_en <= 1'b0;
      PORTB_data     <= 8'h00;
    end
  end

endmodule

// File: tb/tb_portb_ctrl.sv
// Directed scoreboard bench for portb_ctrl: expected acks/strobes are queued
// at drive time and compared when the DUT acknowledges.
module tb_portb_ctrl;

  localparam logic [7:0] A_PINB  = 8'h23;
  localparam logic [7:0] A_DDRB  = 8'h24;
  localparam logic [7:0] A_PORTB = 8'h25;

  typedef struct packed {
    logic       c_ack;
    logic       t_ack;
    logic       wen;
    logic [7:0] data;
    logic [7:0] rdata;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_req = 1'b0;
  logic       cpu_we = 1'b0;
  logic [7:0] cpu_addr = 8'h00;
  logic [1:0] cpu_op = 2'b00;
  logic [7:0] cpu_wdata = 8'h00;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic       tmr_req = 1'b0;
  logic [7:0] tmr_mask = 8'h00;
  logic       tmr_ack;
  logic [7:0] pinb_in = 8'h00;
  logic       PORTB_write_en;
  logic [7:0] PORTB_data;
  logic [7:0] ddrb;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  exp_t sb_q[$];
  exp_t mon_e;

  logic [7:0] m_shadow = 8'h00;
  logic [7:0] m_ddrb   = 8'h00;
  logic [7:0] m_pins   = 8'h00;

  portb_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_op         (cpu_op),
    .cpu_wdata      (cpu_wdata),
    .cpu_ack        (cpu_ack),
    .cpu_rdata      (cpu_rdata),
    .tmr_req        (tmr_req),
    .tmr_mask       (tmr_mask),
    .tmr_ack        (tmr_ack),
    .pinb_in        (pinb_in),
    .PORTB_write_en (PORTB_write_en),
    .PORTB_data     (PORTB_data),
    .ddrb           (ddrb)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] op_model(input logic [1:0] op, input logic [7:0] cur,
                                          input logic [7:0] m);
    logic [7:0] r;
    case (op)
      2'b00:   r = m;
      2'b01:   r = cur | m;
      2'b10:   r = cur & ~m;
      default: r = cur ^ m;
    endcase
    return r;
  endfunction

  function automatic exp_t cpu_expect(input logic we, input logic [7:0] addr,
                                      input logic [1:0] op, input logic [7:0] wd);
    exp_t e;
    e = '{c_ack: 1'b1, t_ack: 1'b0, wen: 1'b0, data: 8'h00, rdata: 8'h00};
    if (we) begin
      if (addr == A_PORTB) begin
        m_shadow = op_model(op, m_shadow, wd);
        e.wen = 1'b1; e.data = m_shadow;
      end else if (addr == A_DDRB) begin
        m_ddrb = op_model(op, m_ddrb, wd);
      end else if (addr == A_PINB) begin
        m_shadow = m_shadow ^ wd;
        e.wen = 1'b1; e.data = m_shadow;
      end
    end else begin
      if (addr == A_PORTB)     e.rdata = m_shadow;
      else if (addr == A_DDRB) e.rdata = m_ddrb;
      else if (addr == A_PINB) e.rdata = m_pins;
    end
    return e;
  endfunction

  function automatic exp_t tmr_expect(input logic [7:0] mask);
    exp_t e;
    m_shadow = m_shadow ^ mask;
    e = '{c_ack: 1'b0, t_ack: 1'b1, wen: 1'b1, data: m_shadow, rdata: 8'h00};
    return e;
  endfunction

  // mode 0: normal, 1: inputs scrambled after latch, 2: request dropped after latch
  task automatic cpu_txn(input logic we, input logic [7:0] addr, input logic [1:0] op,
                         input logic [7:0] wd, input int mode, input string tag);
    int lat;
    sb_q.push_back(cpu_expect(we, addr, op, wd));
    cpu_we = we; cpu_addr = addr; cpu_op = op; cpu_wdata = wd; cpu_req = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (i == 1 && mode == 1) begin
        cpu_we = ~we; cpu_addr = 8'h40; cpu_op = ~op; cpu_wdata = ~wd;
      end
      if (i == 1 && mode == 2) cpu_req = 1'b0;
      if (cpu_ack) begin
        lat = i;
        break;
      end
    end
    cpu_req = 1'b0;
    check({tag, "_latency"}, 8'(lat), 8'd2);
    @(negedge clock);
  endtask

  task automatic tmr_txn(input logic [7:0] mask);
    int lat;
    sb_q.push_back(tmr_expect(mask));
    tmr_mask = mask; tmr_req = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (tmr_ack) begin
        lat = i;
        break;
      end
    end
    tmr_req = 1'b0;
    check("tmr_latency", 8'(lat), 8'd2);
    @(negedge clock);
  endtask

  // both requesters raised together; the queue order encodes who must win
  task automatic tie_txn(input logic we, input logic [7:0] addr, input logic [1:0] op,
                         input logic [7:0] wd, input logic [7:0] mask, input string tag);
    logic c_done, t_done;
    sb_q.push_back(cpu_expect(we, addr, op, wd));
    sb_q.push_back(tmr_expect(mask));
    cpu_we = we; cpu_addr = addr; cpu_op = op; cpu_wdata = wd; cpu_req = 1'b1;
    tmr_mask = mask; tmr_req = 1'b1;
    c_done = 1'b0; t_done = 1'b0;
    for (int i = 0; i < 12 && !(c_done && t_done); i++) begin
      @(negedge clock);
      if (cpu_ack) begin c_done = 1'b1; cpu_req = 1'b0; end
      if (tmr_ack) begin t_done = 1'b1; tmr_req = 1'b0; end
    end
    cpu_req = 1'b0; tmr_req = 1'b0;
    check({tag, "_both_done"}, {6'd0, c_done, t_done}, 8'h03);
    @(negedge clock);
  endtask

  // scoreboard: every ack or strobe must match the oldest expectation
  always @(negedge clock) begin
    if (!reset && (cpu_ack || tmr_ack || PORTB_write_en)) begin
      n_total++;
      assert (sb_q.size() > 0) n_pass++;
      else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed output with empty queue expected none");
      end
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("sb_cpu_ack", {7'd0, cpu_ack}, {7'd0, mon_e.c_ack});
        check("sb_tmr_ack", {7'd0, tmr_ack}, {7'd0, mon_e.t_ack});
        check("sb_write_en", {7'd0, PORTB_write_en}, {7'd0, mon_e.wen});
        check("sb_portb_data", PORTB_data, mon_e.data);
        check("sb_cpu_rdata", cpu_rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clock);
    check("rst_cpu_ack", {7'd0, cpu_ack}, 8'h00);
    check("rst_tmr_ack", {7'd0, tmr_ack}, 8'h00);
    check("rst_write_en", {7'd0, PORTB_write_en}, 8'h00);
    check("rst_portb_data", PORTB_data, 8'h00);
    check("rst_cpu_rdata", cpu_rdata, 8'h00);
    check("rst_ddrb", ddrb, 8'h00);
    reset = 1'b0;
    @(negedge clock);

    // first tie after reset goes to CPU, then timer; next tie again CPU first
    tie_txn(1'b1, A_PORTB, 2'b00, 8'hF0, 8'h01, "tie1");
    check("tie1_shadow_model", m_shadow, 8'hF1);
    tie_txn(1'b0, A_PORTB, 2'b00, 8'h00, 8'h01, "tie2");

    cpu_txn(1'b1, A_PORTB, 2'b00, 8'hA5, 0, "wr_a5");
    cpu_txn(1'b1, A_PORTB, 2'b01, 8'h0A, 0, "set_0a");
    cpu_txn(1'b1, A_PORTB, 2'b10, 8'h21, 0, "clr_21");
    check("clr_model", m_shadow, 8'h8E);
    cpu_txn(1'b1, A_PORTB, 2'b11, 8'h0F, 0, "tog_0f");

    cpu_txn(1'b1, A_PORTB, 2'b00, 8'hFF, 0, "wr_ff");
    cpu_txn(1'b1, A_PINB, 2'b01, 8'h0F, 0, "pinb_tog");
    cpu_txn(1'b0, A_PORTB, 2'b00, 8'h00, 0, "rd_portb");

    cpu_txn(1'b1, A_DDRB, 2'b00, 8'h3C, 0, "ddr_wr");
    cpu_txn(1'b1, A_DDRB, 2'b01, 8'hC0, 0, "ddr_set");
    check("ddrb_after_set", ddrb, 8'hFC);
    cpu_txn(1'b1, A_DDRB, 2'b10, 8'h0F, 0, "ddr_clr");
    cpu_txn(1'b1, A_DDRB, 2'b11, 8'hFF, 0, "ddr_tog");
    check("ddrb_after_tog", ddrb, m_ddrb);
    cpu_txn(1'b0, A_DDRB, 2'b00, 8'h00, 0, "rd_ddrb");

    pinb_in = 8'h3C;
    repeat (2) @(negedge clock);
    m_pins = 8'h3C;
    cpu_txn(1'b0, A_PINB, 2'b00, 8'h00, 0, "rd_pinb");
    cpu_txn(1'b0, 8'h40, 2'b00, 8'h00, 0, "rd_unmapped");
    cpu_txn(1'b1, 8'h40, 2'b00, 8'h55, 0, "wr_unmapped");
    cpu_txn(1'b0, A_PORTB, 2'b00, 8'h00, 0, "rd_after_unmapped");

    tmr_txn(8'h81);
    cpu_txn(1'b1, A_PORTB, 2'b00, 8'h11, 1, "scrambled");
    cpu_txn(1'b1, A_PORTB, 2'b11, 8'h03, 2, "early_drop");

    // reset while the write sits in GRANT must leave no trace
    cpu_we = 1'b1; cpu_addr = A_PORTB; cpu_op = 2'b00; cpu_wdata = 8'h77; cpu_req = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    cpu_req = 1'b0;
    @(negedge clock);
    check("abort_cpu_ack", {7'd0, cpu_ack}, 8'h00);
    check("abort_write_en", {7'd0, PORTB_write_en}, 8'h00);
    check("abort_portb_data", PORTB_data, 8'h00);
    check("abort_ddrb", ddrb, 8'h00);
    reset = 1'b0;
    m_shadow = 8'h00; m_ddrb = 8'h00;
    @(negedge clock);
    check("abort_no_late_ack", {7'd0, cpu_ack}, 8'h00);
    cpu_txn(1'b0, A_PORTB, 2'b00, 8'h00, 0, "rd_after_abort");
    cpu_txn(1'b1, A_PORTB, 2'b00, 8'h5A, 0, "wr_after_abort");

    repeat (3) @(negedge clock);
    check("sb_drained", 8'(sb_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/portb_ctrl.md
PORTB_CTRL -- requirements
Module: portb_ctrl

Interface
REQ-001 Parameter ADDR_PINB, default 8'h23, address of pin-input/toggle register.
REQ-002 Parameter ADDR_DDRB, default 8'h24, address of data-direction register.
REQ-003 Parameter ADDR_PORTB, default 8'h25, address of port data register.
REQ-004 Port clock  input  1  sole clock, all state on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port cpu_req  input  1  CPU bus request, held high until cpu_ack.
REQ-007 Port cpu_we  input  1  1 = write, 0 = read.
REQ-008 Port cpu_addr  input  8  register address.
REQ-009 Port cpu_op  input  2  write op: 00 WRITE, 01 SET, 10 CLEAR, 11 TOGGLE.
REQ-010 Port cpu_wdata  input  8  write data or bit mask.
REQ-011 Port cpu_ack  output  1  one-cycle completion pulse.
REQ-012 Port cpu_rdata  output  8  read data, valid only while cpu_ack = 1, else 0.
REQ-013 Port tmr_req  input  1  timer toggle request, held high until tmr_ack.
REQ-014 Port tmr_mask  input  8  bits of PORTB the timer toggles.
REQ-015 Port tmr_ack  output  1  one-cycle completion pulse.
REQ-016 Port pinb_in  input  8  asynchronous external pin levels.
REQ-017 Port PORTB_write_en  output  1  one-cycle write strobe to the PORTB register.
REQ-018 Port PORTB_data  output  8  value for PORTB, valid while PORTB_write_en = 1.
REQ-019 Port ddrb  output  8  current data-direction register.

Function
REQ-020 FSM states: IDLE, GRANT, COMMIT; IDLE->GRANT when either request is high; GRANT->COMMIT unconditionally; COMMIT->IDLE unconditionally.
REQ-021 Arbitration in IDLE: single requester wins; both high -> round-robin against last_grant; last_grant = TMR after reset (CPU wins first tie).
REQ-022 Winner, address, op, data and mask are latched on IDLE->GRANT; later input changes do not affect the transaction.
REQ-023 The new PORTB value is computed in GRANT from shadow: WRITE = wdata, SET = shadow|wdata, CLEAR = shadow&~wdata, TOGGLE = shadow^wdata; timer = shadow^tmr_mask.
REQ-024 In COMMIT: the winner's ack = 1 for exactly one cycle; a PORTB-modifying transaction also asserts PORTB_write_en = 1 with PORTB_data = new value, and updates shadow.
REQ-025 Latency: request first seen high in IDLE at edge N -> ack and PORTB_write_en high during cycle N+2; throughput one transaction per 3 cycles.
REQ-026 CPU write to ADDR_DDRB applies the same op set to ddrb; no PORTB_write_en.
REQ-027 CPU write to ADDR_PINB: shadow ^ (wdata) regardless of cpu_op; PORTB_write_en asserted.
REQ-028 CPU reads: ADDR_PORTB -> shadow, ADDR_DDRB -> ddrb, ADDR_PINB -> synchronized pins; no state change, no write strobe.
REQ-029 Unmapped address: acked normally, cpu_rdata = 0, no state change, no strobe.
REQ-030 pinb_in passes through a 2-flop synchronizer; PINB read returns the value 2 edges old.
REQ-031 The losing requester remains pending and is granted in the next IDLE cycle.
REQ-032 A request deasserted after latching (illegal) still completes and is acked.

Reset
REQ-033 Reset forces state IDLE, shadow = 0, ddrb = 0, synchronizer = 0, last_grant = TMR, all acks/PORTB_write_en/PORTB_data/cpu_rdata = 0.
REQ-034 Reset mid-transaction aborts it: no ack, no strobe, no shadow update.

Structure
REQ-035 Package portb_pkg holds op-code constants, default register addresses and the FSM state enum.
REQ-036 Sub-module portb_sync2 (8-bit two-flop synchronizer, async reset) instantiated once for pinb_in.

Verification
REQ-037 cpu WRITE 8'hA5 to 8'h25 -> cycle N+2 PORTB_write_en = 1, PORTB_data = 8'hA5, cpu_ack = 1.
REQ-038 shadow 8'hA5, cpu SET 8'h0A, then CLEAR 8'h21 -> PORTB_data 8'hAF then 8'h8E.
REQ-039 cpu_req and tmr_req (mask 8'h01) together from reset, shadow 0 -> CPU WRITE 8'hF0 committed first, tmr then gives 8'hF1; next tie grants CPU.
REQ-040 cpu write 8'h0F to 8'h23 with shadow 8'hFF -> PORTB_data 8'hF0; read 8'h25 returns 8'hF0.
REQ-041 pinb_in = 8'h3C, wait 2 cycles, read 8'h23 -> cpu_rdata 8'h3C; read 8'h40 -> 8'h00, no strobe.
REQ-042 reset asserted during GRANT -> no ack, outputs 0, ddrb 0; next write after release completes normally.
